// File: rtl/instr_pkg.sv
// instr_pkg: shared instruction word format and loader FSM states.
//  OP_W/REG_W/INSTR_W : field and word widths
//  instr_t            : packed {op, r1, r2}; the read side decodes through it
//  loader_state_e     : instr_loader FSM states
package instr_pkg;

  localparam int OP_W    = 3;
  localparam int REG_W   = 3;
  localparam int INSTR_W = OP_W + 2 * REG_W;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] r1;
    logic [REG_W-1:0] r2;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  function automatic instr_t pack_instr(input logic [OP_W-1:0]  op,
                                        input logic [REG_W-1:0] r1,
                                        input logic [REG_W-1:0] r2);
    instr_t w;
    w.op = op;
    w.r1 = r1;
    w.r2 = r2;
    return w;
  endfunction

endpackage

// File: rtl/instr_addr_ctr.sv
// instr_addr_ctr: loadable write-address counter plus words-remaining
// down-counter for instr_loader.
//  clk, reset  : clock, async active-high reset
//  load        : take base_pc / num_words (has priority over step)
//  step        : one word accepted; addr+1 (mod 2**PC_BITS), remaining-1
//  base_pc     : start address
//  num_words   : word count to load
//  addr        : current write address
//  at_top      : addr is all ones, so the next step wraps to 0
//  last        : one word remains, so the next step empties the counter
//  load_zero   : num_words input is zero (empty load request)
module instr_addr_ctr #(
  parameter int PC_BITS = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [PC_BITS-1:0] base_pc,
  input  logic [PC_BITS:0]   num_words,
  output logic [PC_BITS-1:0] addr,
  output logic               at_top,
  output logic               last,
  output logic               load_zero
);

  localparam logic [PC_BITS-1:0] ADDR_ONE = PC_BITS'(1);
  localparam logic [PC_BITS:0]   REM_ONE  = (PC_BITS + 1)'(1);

  logic [PC_BITS-1:0] addr_q, addr_d;
  logic [PC_BITS:0]   rem_q, rem_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = base_pc;
      rem_d  = num_words;
    end else if (step) begin
      addr_d = addr_q + ADDR_ONE;
      rem_d  = rem_q - REM_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr      = addr_q;
  assign at_top    = &addr_q;
  assign last      = (rem_q == REM_ONE);
  assign load_zero = (num_words == '0);

endmodule

// File: rtl/instr_loader.sv
// instr_loader: loads a program into instruction memory. Accepts decoded
// (op, r1, r2) triples on a valid/ready stream, packs each into a 9-bit word
// and writes it at consecutive addresses starting at base_pc.
//  clk, reset          : clock, async active-high reset
//  start               : 1-cycle pulse, honoured only in IDLE
//  base_pc, num_words  : load setup, sampled with start (num_words may be 0)
//  abort               : end the load after any same-cycle handshake
//  in_valid/in_ready   : input stream handshake
//  in_op, in_r1, in_r2 : instruction fields
//  wr_en/wr_addr/wr_data : memory write port, one cycle after the handshake
//  busy                : high in LOAD and FLUSH
//  done                : 1-cycle pulse in DONE
//  wrapped             : sticky, address wrapped past the top during this load
module instr_loader
  import instr_pkg::*;
#(
  parameter int PC_BITS = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_BITS-1:0] base_pc,
  input  logic [PC_BITS:0]   num_words,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [REG_W-1:0]   in_r1,
  input  logic [REG_W-1:0]   in_r2,
  output logic               wr_en,
  output logic [PC_BITS-1:0] wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               wrapped
);

  loader_state_e      state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [PC_BITS-1:0] wr_addr_q, wr_addr_d;
  instr_t             wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrapped_q, wrapped_d;

  logic               hs, ctr_load;
  logic [PC_BITS-1:0] addr;
  logic               at_top, last, load_zero;

  // in_ready_q is only ever high in LOAD, so hs needs no state qualifier.
  assign hs       = in_valid & in_ready_q;
  assign ctr_load = (state_q == IDLE) & start;

  instr_addr_ctr #(.PC_BITS(PC_BITS)) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (ctr_load),
    .step      (hs),
    .base_pc   (base_pc),
    .num_words (num_words),
    .addr      (addr),
    .at_top    (at_top),
    .last      (last),
    .load_zero (load_zero)
  );

  always_comb begin
    state_d   = state_q;
    wrapped_d = wrapped_q;
    wr_en_d   = hs;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (hs) begin
      wr_addr_d = addr;
      wr_data_d = pack_instr(in_op, in_r1, in_r2);
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          wrapped_d = 1'b0;
          state_d   = load_zero ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (hs && at_top) wrapped_d = 1'b1;
        // A word handshaken alongside abort is still written via wr_en_d.
        if (abort || (hs && last)) state_d = FLUSH;
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d == LOAD) || (state_d == FLUSH);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrapped_q  <= wrapped_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrapped  = wrapped_q;

endmodule
